// File: rtl/msh_pkg.sv
// msh_pkg: shared mesh memory-request types and sizing constants.
//   MSH_MEM_ADDR_W / MSH_MEM_DATA_W : request field widths
//   MSH_MEM_REQ_DEPTH               : default request queue depth (= sender credits)
//   MSH_MEM_OCC_W                   : occupancy width for the default depth
//   msh_mem_req_t                   : queued request {wr, addr, data}
// Optional macro MSH_MEM_REQ_PARITY_EN adds a poison bit to msh_mem_req_t.
package msh_pkg;
    localparam int MSH_MEM_ADDR_W    = 16;
    localparam int MSH_MEM_DATA_W    = 64;
    localparam int MSH_MEM_REQ_DEPTH = 8;
    localparam int MSH_MEM_OCC_W     = $clog2(MSH_MEM_REQ_DEPTH + 1);

    typedef struct packed {
`ifdef MSH_MEM_REQ_PARITY_EN
        logic                      poison;
`endif
        logic                      wr;
        logic [MSH_MEM_ADDR_W-1:0] addr;
        logic [MSH_MEM_DATA_W-1:0] data;
    } msh_mem_req_t;
endpackage

// File: rtl/msh_mem_req_ptr.sv
// msh_mem_req_ptr: FIFO read/write pointers with an extra wrap bit, plus
// occupancy and full flag. Reusable for request- and response-side queues.
//   clk_i, rst_ni        : clock, async active-low reset
//   push_i, pop_i        : qualified push / pop (caller guarantees legality)
//   wr_idx_o             : storage slot for the current push
//   rd_idx_nxt_o         : head slot after this cycle's pop
//   occ_o, full_o        : current occupancy and full flag
//   nonempty_nxt_o       : queue will hold at least one entry next cycle
module msh_mem_req_ptr #(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH)-1:0]   wr_idx_o,
    output logic [$clog2(DEPTH)-1:0]   rd_idx_nxt_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o,
    output logic                       full_o,
    output logic                       nonempty_nxt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

    assign wptr_d = wptr_q + PW'(push_i);
    assign rptr_d = rptr_q + PW'(pop_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Wrap bit makes the pointer difference span 0..DEPTH, so full and empty
    // are distinguishable even though the slot indices coincide.
    assign occ_o          = wptr_q - rptr_q;
    assign full_o         = (occ_o == PW'(DEPTH));
    assign wr_idx_o       = wptr_q[AW-1:0];
    assign rd_idx_nxt_o   = rptr_d[AW-1:0];
    assign nonempty_nxt_o = (wptr_d != rptr_d);
endmodule

// File: rtl/msh_mem_req_q.sv
// msh_mem_req_q: credit-based ingress request queue feeding msh_mem_dp.
// Pushes are never stalled (sender is credit-limited); the head is presented
// on registered valid/ready outputs and each pop returns one credit.
//   mclk, mrst_n                       : clock, async active-low reset
//   i_req_vld/wr/addr/data             : ingress push
//   o_req_vld/wr/addr/data, i_req_rdy  : head toward msh_mem_dp
//   o_crd_rtn                          : one pulse per pop, cycle after pop
//   o_occ                              : occupancy
//   o_ovfl_err                         : sticky push-while-full error
// Optional macro MSH_MEM_REQ_PARITY_EN adds i_req_par, o_req_poison and
// o_par_err (even parity over {wr, addr, data, par}, sticky error).
module msh_mem_req_q
    import msh_pkg::*;
#(
    parameter int DEPTH  = MSH_MEM_REQ_DEPTH,
    parameter int ADDR_W = MSH_MEM_ADDR_W,
    parameter int DATA_W = MSH_MEM_DATA_W
) (
    input  logic                       mclk,
    input  logic                       mrst_n,
    input  logic                       i_req_vld,
    input  logic                       i_req_wr,
    input  logic [ADDR_W-1:0]          i_req_addr,
    input  logic [DATA_W-1:0]          i_req_data,
`ifdef MSH_MEM_REQ_PARITY_EN
    input  logic                       i_req_par,
    output logic                       o_req_poison,
    output logic                       o_par_err,
`endif
    output logic                       o_crd_rtn,
    output logic                       o_req_vld,
    input  logic                       i_req_rdy,
    output logic                       o_req_wr,
    output logic [ADDR_W-1:0]          o_req_addr,
    output logic [DATA_W-1:0]          o_req_data,
    output logic [$clog2(DEPTH+1)-1:0] o_occ,
    output logic                       o_ovfl_err
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]              wr_idx, rd_idx_nxt;
    logic [$clog2(DEPTH+1)-1:0] occ;
    logic                       full, nonempty_nxt, push, pop;
    msh_mem_req_t               mem_q [DEPTH];
    msh_mem_req_t               in_req, head_q, head_d;
    logic                       vld_q, crd_q, ovfl_q;

    // Overflow is judged on occupancy before any same-cycle pop.
    assign push = i_req_vld & ~full;
    assign pop  = vld_q & i_req_rdy;

    msh_mem_req_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk_i          (mclk),
        .rst_ni         (mrst_n),
        .push_i         (push),
        .pop_i          (pop),
        .wr_idx_o       (wr_idx),
        .rd_idx_nxt_o   (rd_idx_nxt),
        .occ_o          (occ),
        .full_o         (full),
        .nonempty_nxt_o (nonempty_nxt)
    );

    always_comb begin
        in_req      = '0;
        in_req.wr   = i_req_wr;
        in_req.addr = i_req_addr;
        in_req.data = i_req_data;
`ifdef MSH_MEM_REQ_PARITY_EN
        in_req.poison = ^{i_req_wr, i_req_addr, i_req_data, i_req_par};
`endif
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge mclk) begin
        if (push) mem_q[wr_idx] <= in_req;
    end

    // Head register is loaded with what will be at the head next cycle.
    // When the new head slot is the one being written this cycle (queue
    // empty after any pop), take the incoming request directly. When the
    // queue will be empty, hold the last head.
    always_comb begin
        head_d = head_q;
        if (nonempty_nxt) begin
            if (push && (wr_idx == rd_idx_nxt)) head_d = in_req;
            else                                head_d = mem_q[rd_idx_nxt];
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            head_q <= '0;
            vld_q  <= 1'b0;
            crd_q  <= 1'b0;
            ovfl_q <= 1'b0;
        end else begin
            head_q <= head_d;
            vld_q  <= nonempty_nxt;
            crd_q  <= pop;
            ovfl_q <= ovfl_q | (i_req_vld & full);
        end
    end

`ifdef MSH_MEM_REQ_PARITY_EN
    logic par_err_q;
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) par_err_q <= 1'b0;
        else         par_err_q <= par_err_q | (push & in_req.poison);
    end
    assign o_par_err    = par_err_q;
    assign o_req_poison = head_q.poison;
`endif

    assign o_req_vld  = vld_q;
    assign o_req_wr   = head_q.wr;
    assign o_req_addr = head_q.addr;
    assign o_req_data = head_q.data;
    assign o_crd_rtn  = crd_q;
    assign o_occ      = occ;
    assign o_ovfl_err = ovfl_q;
endmodule

// File: tb/tb_msh_mem_req_q.sv
module tb_msh_mem_req_q;
    localparam int DEPTH = 8;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
        logic        poison;
    } ent_t;

    logic        mclk = 1'b0;
    logic        mrst_n = 1'b0;
    logic        i_req_vld = 1'b0, i_req_wr = 1'b0, i_req_rdy = 1'b0;
    logic [15:0] i_req_addr = '0;
    logic [63:0] i_req_data = '0;
    logic        o_crd_rtn, o_req_vld, o_req_wr, o_ovfl_err;
    logic [15:0] o_req_addr;
    logic [63:0] o_req_data;
    logic [3:0]  o_occ;
`ifdef MSH_MEM_REQ_PARITY_EN
    logic        i_req_par = 1'b0;
    logic        o_req_poison, o_par_err;
`endif

    int n_tot = 0, n_pass = 0;

    // Reference model: a queue of whole requests plus sticky flags.
    ent_t m_q[$];
    ent_t m_head;
    bit   m_crd, m_ovfl, m_par;

    always #5 mclk = ~mclk;

    msh_mem_req_q dut (
        .mclk       (mclk),
        .mrst_n     (mrst_n),
        .i_req_vld  (i_req_vld),
        .i_req_wr   (i_req_wr),
        .i_req_addr (i_req_addr),
        .i_req_data (i_req_data),
`ifdef MSH_MEM_REQ_PARITY_EN
        .i_req_par    (i_req_par),
        .o_req_poison (o_req_poison),
        .o_par_err    (o_par_err),
`endif
        .o_crd_rtn  (o_crd_rtn),
        .o_req_vld  (o_req_vld),
        .i_req_rdy  (i_req_rdy),
        .o_req_wr   (o_req_wr),
        .o_req_addr (o_req_addr),
        .o_req_data (o_req_data),
        .o_occ      (o_occ),
        .o_ovfl_err (o_ovfl_err)
    );

    task automatic model_reset();
        m_q.delete();
        m_head = '{wr: 1'b0, addr: 16'h0, data: 64'h0, poison: 1'b0};
        m_crd = 0; m_ovfl = 0; m_par = 0;
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, and
    // leave time 1 unit past the edge for sampling.
    task automatic step(input bit v, input bit w, input logic [15:0] a,
                        input logic [63:0] d, input bit r, input bit bad);
        bit   pop, full;
        ent_t e;
        i_req_vld = v; i_req_wr = w; i_req_addr = a; i_req_data = d; i_req_rdy = r;
`ifdef MSH_MEM_REQ_PARITY_EN
        i_req_par = (^{w, a, d}) ^ bad;
`endif
        @(posedge mclk);
        pop  = (m_q.size() > 0) && r;
        full = (m_q.size() == DEPTH);
        if (v && full) m_ovfl = 1;
        if (pop) m_q.delete(0);
        if (v && !full) begin
            e = '{wr: w, addr: a, data: d, poison: bad};
            m_q.push_back(e);
            if (bad) m_par = 1;
        end
        m_crd = pop;
        if (m_q.size() > 0) m_head = m_q[0];
        #1;
    endtask

    task automatic test_reset();
        mrst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        n_tot++;
        if ({o_req_vld, o_crd_rtn, o_ovfl_err, o_occ, o_req_wr, o_req_addr, o_req_data} !== '0)
            $display("FAIL reset_state: got vld=%0b crd=%0b ovfl=%0b occ=%0d wr=%0b addr=%h data=%h, want all 0",
                     o_req_vld, o_crd_rtn, o_ovfl_err, o_occ, o_req_wr, o_req_addr, o_req_data);
        else n_pass++;
        mrst_n = 1'b1;
        step(0, 0, 0, 0, 1, 0);
        n_tot++;
        if ({o_req_vld, o_crd_rtn, o_occ} !== '0)
            $display("FAIL idle_empty_rdy: got vld=%0b crd=%0b occ=%0d, want 0 0 0", o_req_vld, o_crd_rtn, o_occ);
        else n_pass++;
    endtask

    task automatic test_single();
        step(1, 1, 16'h0010, 64'hA5A5, 1, 0);
        n_tot++;
        if ({o_req_vld, o_req_wr, o_req_addr, o_req_data, o_occ, o_crd_rtn} !== {1'b1, 1'b1, 16'h0010, 64'hA5A5, 4'd1, 1'b0})
            $display("FAIL single_head: got vld=%0b wr=%0b addr=%h data=%h occ=%0d crd=%0b, want 1 1 0010 a5a5 1 0",
                     o_req_vld, o_req_wr, o_req_addr, o_req_data, o_occ, o_crd_rtn);
        else n_pass++;
        step(0, 0, 0, 0, 1, 0);
        n_tot++;
        if ({o_req_vld, o_occ, o_crd_rtn} !== {1'b0, 4'd0, 1'b1})
            $display("FAIL single_pop: got vld=%0b occ=%0d crd=%0b, want 0 0 1", o_req_vld, o_occ, o_crd_rtn);
        else n_pass++;
        step(0, 0, 0, 0, 0, 0);
        n_tot++;
        if ({o_crd_rtn, o_req_addr} !== {1'b0, 16'h0010})
            $display("FAIL single_crd_once: got crd=%0b addr=%h, want 0 0010", o_crd_rtn, o_req_addr);
        else n_pass++;
    endtask

    task automatic test_fill_ovfl();
        for (int i = 0; i < DEPTH; i++)
            step(1, 1'($urandom), 16'(i), {$urandom, $urandom}, 0, 0);
        n_tot++;
        if ({o_occ, o_ovfl_err, o_req_vld, o_req_addr} !== {4'd8, 1'b0, 1'b1, 16'h0000})
            $display("FAIL fill_full: got occ=%0d ovfl=%0b vld=%0b addr=%h, want 8 0 1 0000",
                     o_occ, o_ovfl_err, o_req_vld, o_req_addr);
        else n_pass++;
        step(1, 0, 16'h0099, 64'h99, 0, 0);
        n_tot++;
        if ({o_occ, o_ovfl_err} !== {4'd8, 1'b1})
            $display("FAIL overflow: got occ=%0d ovfl=%0b, want 8 1", o_occ, o_ovfl_err);
        else n_pass++;
    endtask

    task automatic test_drain();
        int crd = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n_tot++;
            if (!(o_req_vld === 1'b1 && o_req_addr === 16'(i) && o_req_data === m_head.data))
                $display("FAIL drain_order[%0d]: got vld=%0b addr=%h data=%h, want 1 %h %h",
                         i, o_req_vld, o_req_addr, o_req_data, 16'(i), m_head.data);
            else n_pass++;
            step(0, 0, 0, 0, 1, 0);
            if (o_crd_rtn === 1'b1) crd++;
        end
        n_tot++;
        if (crd !== DEPTH || o_occ !== 4'd0 || o_ovfl_err !== 1'b1 || o_req_vld !== 1'b0)
            $display("FAIL drain_end: got crd=%0d occ=%0d ovfl=%0b vld=%0b, want 8 0 1 0",
                     crd, o_occ, o_ovfl_err, o_req_vld);
        else n_pass++;
        step(0, 0, 0, 0, 1, 0);
        n_tot++;
        if ({o_crd_rtn, o_req_vld, o_req_addr} !== {1'b0, 1'b0, 16'h0007})
            $display("FAIL drain_idle: got crd=%0b vld=%0b addr=%h, want 0 0 0007", o_crd_rtn, o_req_vld, o_req_addr);
        else n_pass++;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) step(1, 0, 16'h0100 + 16'(k), {$urandom, $urandom}, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(1, 1'($urandom), 16'h0103 + 16'(k), {$urandom, $urandom}, 1, 0);
            n_tot++;
            if (o_occ !== 4'd3 || o_crd_rtn !== 1'b1 || o_req_addr !== 16'h0101 + 16'(k) ||
                o_req_data !== m_head.data || o_req_wr !== m_head.wr)
                $display("FAIL stream[%0d]: got occ=%0d crd=%0b addr=%h data=%h, want 3 1 %h %h",
                         k, o_occ, o_crd_rtn, o_req_addr, o_req_data, 16'h0101 + 16'(k), m_head.data);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 16'h0200, 64'h1, 0, 0);
        step(1, 0, 16'h0201, 64'h2, 0, 0);
        n_tot++;
        if (o_occ !== 4'd5)
            $display("FAIL mid_occ5: got occ=%0d, want 5", o_occ);
        else n_pass++;
        mrst_n = 1'b0;
        model_reset();
        #1;
        n_tot++;
        if ({o_req_vld, o_crd_rtn, o_ovfl_err, o_occ, o_req_wr, o_req_addr, o_req_data} !== '0)
            $display("FAIL mid_reset_outputs: got vld=%0b crd=%0b occ=%0d addr=%h data=%h, want all 0",
                     o_req_vld, o_crd_rtn, o_occ, o_req_addr, o_req_data);
        else n_pass++;
        @(posedge mclk);
        #1 mrst_n = 1'b1;
        step(1, 0, 16'h0BEE, 64'hC0FFEE, 0, 0);
        n_tot++;
        if ({o_req_vld, o_req_addr, o_req_data, o_occ} !== {1'b1, 16'h0BEE, 64'hC0FFEE, 4'd1})
            $display("FAIL mid_new_push: got vld=%0b addr=%h data=%h occ=%0d, want 1 0bee c0ffee 1",
                     o_req_vld, o_req_addr, o_req_data, o_occ);
        else n_pass++;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        n_tot++;
        if ({o_req_vld, o_occ} !== {1'b0, 4'd0})
            $display("FAIL mid_no_stale: got vld=%0b occ=%0d, want 0 0", o_req_vld, o_occ);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] eo;
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) < 6, 1'($urandom), 16'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 9) < 5, 0);
            eo = 4'(m_q.size());
            n_tot++;
            if ({o_req_vld, o_crd_rtn, o_ovfl_err, o_occ, o_req_wr, o_req_addr, o_req_data} !==
                {m_q.size() > 0, m_crd, m_ovfl, eo, m_head.wr, m_head.addr, m_head.data})
                $display("FAIL random[%0d]: got vld=%0b crd=%0b ovfl=%0b occ=%0d addr=%h, want %0b %0b %0b %0d %h",
                         c, o_req_vld, o_crd_rtn, o_ovfl_err, o_occ, o_req_addr,
                         m_q.size() > 0, m_crd, m_ovfl, eo, m_head.addr);
            else n_pass++;
        end
    endtask

`ifdef MSH_MEM_REQ_PARITY_EN
    task automatic test_parity();
        test_reset();
        step(1, 1, 16'h0300, 64'hDEAD, 0, 1);
        n_tot++;
        if ({o_req_vld, o_req_poison, o_par_err} !== 3'b111)
            $display("FAIL parity_bad: got vld=%0b poison=%0b par_err=%0b, want 1 1 1", o_req_vld, o_req_poison, o_par_err);
        else n_pass++;
        step(1, 0, 16'h0301, 64'hBEEF, 1, 0);
        n_tot++;
        if ({o_req_addr, o_req_poison, o_par_err, o_occ} !== {16'h0301, 1'b0, 1'b1, 4'd1})
            $display("FAIL parity_good: got addr=%h poison=%0b par_err=%0b occ=%0d, want 0301 0 1 1",
                     o_req_addr, o_req_poison, o_par_err, o_occ);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_ovfl();
        test_drain();
        test_stream();
        test_reset_mid();
        test_random();
`ifdef MSH_MEM_REQ_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/msh_mem_req_q.md
Name: msh_mem_req_q

Overview:
- Credit-based ingress request queue sitting directly upstream of msh_mem_dp in a mesh node.
- Accepts read/write requests from the mesh port side without backpressure; the sender is governed by credits.
- Buffers requests in a FIFO and presents them to msh_mem_dp over a valid/ready interface.
- Returns one credit per request consumed.

Parameters:
- DEPTH, 8: queue entries; power of two, minimum 2; equals the initial sender credit count.
- ADDR_W, MSH_MEM_ADDR_W (16): request address width.
- DATA_W, MSH_MEM_DATA_W (64): write data width.

Ports:
- mclk  in  1  mesh clock; all logic on its rising edge.
- mrst_n  in  1  asynchronous active-low reset.
- i_req_vld  in  1  ingress request valid; one push per cycle, never stalled.
- i_req_wr  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  request address.
- i_req_data  in  DATA_W  write data; don't-care for reads.
- o_crd_rtn  out  1  one-cycle pulse returning one credit to the sender.
- o_req_vld  out  1  head entry valid toward msh_mem_dp.
- i_req_rdy  in  1  msh_mem_dp accepts the head entry.
- o_req_wr  out  1  head entry write flag.
- o_req_addr  out  ADDR_W  head entry address.
- o_req_data  out  DATA_W  head entry data.
- o_occ  out  $clog2(DEPTH+1)  current occupancy.
- o_ovfl_err  out  1  sticky overflow error.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Write/read pointers, occupancy, o_crd_rtn, o_ovfl_err and o_req_vld all go to 0.
  - o_req_wr, o_req_addr and o_req_data go to 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all queued entries. The sender re-initialises to DEPTH credits.
- Push: i_req_vld=1 and occ<DEPTH writes the entry at wptr; wptr increments modulo DEPTH.
- Pop: o_req_vld=1 and i_req_rdy=1 retires the head entry; rptr increments modulo DEPTH.
- Output timing:
  - Head outputs are registered.
  - A push into an empty queue gives o_req_vld=1 on the next cycle (latency 1), with no bypass.
  - Head fields remain stable while o_req_vld=1 and i_req_rdy=0.
  - When the queue is empty, o_req_vld=0 and the head fields hold their last value.
- Credit return: o_crd_rtn=1 in the cycle after each pop, registered. It carries exactly one pulse per pop, including back-to-back pops.
- Occupancy: o_occ = occ + push - pop, updated every cycle. Simultaneous push and pop leaves occupancy unchanged.
- Overflow:
  - i_req_vld=1 while occ==DEPTH is a protocol violation, evaluated before any same-cycle pop.
  - The request is dropped and o_ovfl_err is set to 1 and held until reset.
  - A same-cycle pop still completes normally.
- Empty with i_req_rdy=1: no pop, no credit returned.
- Pointer wrap: the extra MSB on each pointer distinguishes full from empty.

Optional Feature:
- Macro: MSH_MEM_REQ_PARITY_EN.
- Enabled:
  - Adds ports i_req_par (in, 1), o_req_poison (out, 1) and o_par_err (out, 1, sticky).
  - On push, even parity is checked over {wr, addr, data, par}.
  - A mismatching entry is still enqueued with a poison bit set, presented on o_req_poison with the head entry, and sets o_par_err.
  - Credit accounting is unchanged.
  - o_req_poison and o_par_err reset to 0.
- Disabled: these ports and the parity logic do not exist; all other behaviour is identical.

Decomposition:
- msh_pkg holds:
  - MSH_MEM_ADDR_W, MSH_MEM_DATA_W, MSH_MEM_REQ_DEPTH.
  - Typedef msh_mem_req_t {wr, addr, data}, extended with poison under the macro.
  - Occupancy width constant.
- One sub-module, msh_mem_req_ptr: pointer and occupancy counter with full/empty generation, reusable for the response-side queue.
- Storage is an internal flop array of msh_mem_req_t.

Test Plan:
- Reset, then push a write (addr 0x0010, data 0xA5A5) with i_req_rdy=1:
  - o_req_vld=1 the next cycle with matching fields.
  - Pop occurs that cycle; o_crd_rtn pulses one cycle later; o_occ sequence is 0,1,0.
- i_req_rdy=0 and push 8 requests (addr 0..7):
  - o_occ=8.
  - A 9th push sets o_ovfl_err=1; o_occ stays 8; the 9th request is never output.
- From full, release i_req_rdy=1 for 8 cycles:
  - Addrs 0..7 appear in order.
  - 8 o_crd_rtn pulses occur; o_occ reaches 0; o_ovfl_err remains 1.
- Continuous push and pop for 20 cycles with occ=3:
  - o_occ constant at 3 and data in order across pointer wrap.
  - o_crd_rtn=1 every cycle.
- Assert mrst_n=0 mid-stream with occ=5:
  - All outputs go to 0 immediately.
  - After release, a new push yields o_req_vld after 1 cycle and no stale entry appears.
- With MSH_MEM_REQ_PARITY_EN, push with a bad i_req_par:
  - The entry is output with o_req_poison=1 and o_par_err=1 sticky.
  - The next good entry has o_req_poison=0.
